// File: rtl/mac_accum_sat_32_2sc_pkg.sv
// Shared constants and types for the saturating frame MAC accumulator.
// Holds the multiplier latency, accumulator width and Q31 clip limits.
package mac_accum_sat_32_2sc_pkg;

    localparam int unsigned MULT_LAT_DEF = 32;
    localparam int unsigned ACC_W_DEF    = 72;

    localparam logic [31:0] Q31_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q31_MIN = 32'h8000_0000;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

endpackage

// File: rtl/mac_accum_sat_32_2sc_tag_delay_line.sv
// WIDTH x DEPTH shift register with asynchronous clear.
// Carries operand tags alongside the un-tagged multiplier pipeline.
module mac_accum_sat_32_2sc_tag_delay_line #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 32
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/mac_accum_sat_32_2sc.sv
// Frame accumulator behind the 32-stage multiplier: sums products per frame,
// then rounds, shifts and clips the total to Q31 with a one-cycle valid pulse.
module mac_accum_sat_32_2sc
    import mac_accum_sat_32_2sc_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned ACC_W    = ACC_W_DEF,
    parameter int unsigned SHIFT    = 31,
    parameter int unsigned MAX_LEN  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [63:0] y,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_sat,
    output logic        out_err
);

    localparam int unsigned      CNT_W    = $clog2(MAX_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_LEN + 1);
    localparam logic [ACC_W:0]   RND_BIAS = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);

    tag_t w_tag_in;
    tag_t w_tag_out;

    logic [ACC_W-1:0]        r_acc;
    logic [ACC_W-1:0]        w_sum;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    r_first;
    logic [ACC_W:0]          w_rnd;
    logic signed [ACC_W:0]   w_r;
    logic                    w_pos_ovf;
    logic                    w_neg_ovf;

    logic [31:0] r_out_data;
    logic        r_out_valid;
    logic        r_out_sat;
    logic        r_out_err;

    assign w_tag_in = '{valid: in_valid, last: in_valid & in_last};

    mac_accum_sat_32_2sc_tag_delay_line #(
        .WIDTH (2),
        .DEPTH (MULT_LAT)
    ) u_tag_delay_line (
        .i_clk (clk),
        .i_clr (reset),
        .i_d   (w_tag_in),
        .o_q   (w_tag_out)
    );

    // Close-of-frame result is taken from this sum, not from r_acc, so the
    // last product is included without an extra cycle.
    assign w_sum = (r_first ? '0 : r_acc) + {{(ACC_W-64){y[63]}}, y};

    assign w_rnd = {w_sum[ACC_W-1], w_sum} + RND_BIAS;
    assign w_r   = $signed(w_rnd) >>> SHIFT;

    // Result fits in Q31 only when bits [ACC_W:31] are all copies of the sign.
    assign w_pos_ovf = ~w_r[ACC_W] & (|w_r[ACC_W-1:31]);
    assign w_neg_ovf =  w_r[ACC_W] & ~(&w_r[ACC_W-1:31]);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_first) begin
            w_cnt_nxt = CNT_ONE;
        end else if (r_cnt != CNT_SAT) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_first     <= 1'b1;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
            r_out_err   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_tag_out.valid) begin
                r_acc   <= w_sum;
                r_cnt   <= w_cnt_nxt;
                r_first <= w_tag_out.last;
                if (w_tag_out.last) begin
                    r_out_valid <= 1'b1;
                    r_out_err   <= (w_cnt_nxt > CNT_MAX);
                    r_out_sat   <= w_pos_ovf | w_neg_ovf;
                    if (w_pos_ovf) begin
                        r_out_data <= Q31_MAX;
                    end else if (w_neg_ovf) begin
                        r_out_data <= Q31_MIN;
                    end else begin
                        r_out_data <= w_r[31:0];
                    end
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sat   = r_out_sat;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_mac_accum_sat_32_2sc.sv
// Bench for mac_accum_sat_32_2sc: behavioural multiplier in front, frame-level
// reference model and scoreboard behind, plus table and hand-written corner cases.
module tb_mac_accum_sat_32_2sc;

    localparam int LAT = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_last;
    logic [63:0] y;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_sat;
    logic        out_err;

    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    logic [63:0] pipe [LAT];

    int     total = 0;
    int     bad = 0;
    int     pulses = 0;
    longint cyc = 0;

    logic [31:0] obs_data;
    logic        obs_sat;
    logic        obs_err;
    longint      obs_cyc;

    typedef struct {
        logic [31:0] data;
        logic        sat;
        logic        err;
        longint      due;
    } exp_t;
    exp_t expq[$];
    exp_t e;

    logic signed [71:0] m_acc;
    int                 m_cnt;
    bit                 m_first;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_sat;
    } vec_t;
    vec_t tab [8];

    mac_accum_sat_32_2sc dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .y         (y),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sat   (out_sat),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Stand-in for the un-reset 32-stage multiplier.
    assign prod = longint'($signed(a)) * longint'($signed(b));
    always @(posedge clk) begin
        pipe[0] <= prod;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign y = pipe[LAT-1];

    always @(posedge clk) cyc = cyc + 1;

    // Frame-level reference: exact signed sum, round-half-up, clip to Q31.
    task automatic model_op(input logic [31:0] a_i, input logic [31:0] b_i, input bit last_i,
                            input longint due_i);
        logic signed [71:0] p;
        logic signed [72:0] s;
        logic signed [72:0] r;
        exp_t x;
        p = 72'(longint'($signed(a_i)) * longint'($signed(b_i)));
        m_acc = (m_first ? 72'sd0 : m_acc) + p;
        m_cnt = m_first ? 1 : m_cnt + 1;
        m_first = last_i;
        if (last_i) begin
            s = 73'(m_acc) + 73'sd1073741824;
            r = s >>> 31;
            if (r > 73'sd2147483647) begin
                x.data = 32'h7FFF_FFFF; x.sat = 1'b1;
            end else if (r < -73'sd2147483648) begin
                x.data = 32'h8000_0000; x.sat = 1'b1;
            end else begin
                x.data = r[31:0]; x.sat = 1'b0;
            end
            x.err = (m_cnt > 256);
            x.due = due_i;
            expq.push_back(x);
        end
    endtask

    task automatic drive(input bit v, input bit l, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        in_valid = v;
        in_last  = l;
        a = av;
        b = bv;
        if (v) model_op(av, bv, l, cyc + 1 + LAT);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic wait_pulse(input int p0, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (pulses > p0) ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: no out_valid pulse within 80 cycles", name);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        expq.delete();
        m_first = 1'b1;
        m_acc = '0;
        m_cnt = 0;
        #1;
        check("rst_data", out_data, 32'h0);
        check("rst_valid", {31'd0, out_valid}, 32'h0);
        check("rst_sat", {31'd0, out_sat}, 32'h0);
        check("rst_err", {31'd0, out_err}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: every pulse must match the oldest expectation at its due cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (expq.size() > 0 && expq[0].due < cyc) begin
                total++;
                bad++;
                $display("FAIL missed_pulse: none at cycle %0d, expected data=%h", expq[0].due,
                         expq[0].data);
                void'(expq.pop_front());
            end
            if (out_valid) begin
                pulses++;
                obs_data = out_data;
                obs_sat  = out_sat;
                obs_err  = out_err;
                obs_cyc  = cyc;
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: data=%h at cycle %0d, expected none",
                             out_data, cyc);
                end else begin
                    e = expq.pop_front();
                    if ({out_data, out_sat, out_err} !== {e.data, e.sat, e.err} || cyc != e.due)
                    begin
                        bad++;
                        $display("FAIL scoreboard: got data=%h sat=%b err=%b cyc=%0d, expected data=%h sat=%b err=%b cyc=%0d",
                                 out_data, out_sat, out_err, cyc, e.data, e.sat, e.err, e.due);
                    end
                end
            end
        end
    end

    initial begin
        bit     ok;
        int     p0;
        longint se;
        longint cyc_a;

        tab[0] = '{32'h4000_0000, 32'h4000_0000, 32'h2000_0000, 1'b0};
        tab[1] = '{32'h0000_8000, 32'h0000_8000, 32'h0000_0001, 1'b0};
        tab[2] = '{32'hFFFF_8000, 32'h0000_8000, 32'h0000_0000, 1'b0};
        tab[3] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        tab[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFE, 1'b0};
        tab[5] = '{32'hC000_0000, 32'h4000_0000, 32'hE000_0000, 1'b0};
        tab[6] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        tab[7] = '{32'h2000_0000, 32'h2000_0000, 32'h0800_0000, 1'b0};

        reset = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        a = '0;
        b = '0;
        m_first = 1'b1;
        m_acc = '0;
        m_cnt = 0;
        repeat (2) @(negedge clk);
        check("init_data", out_data, 32'h0);
        check("init_valid", {31'd0, out_valid}, 32'h0);
        check("init_sat", {31'd0, out_sat}, 32'h0);
        check("init_err", {31'd0, out_err}, 32'h0);
        reset = 1'b0;

        // Single-product frames from the table.
        for (int i = 0; i < 8; i++) begin
            p0 = pulses;
            drive(1, 1, tab[i].a, tab[i].b);
            se = cyc + 1;
            drive(0, 0, 0, 0);
            wait_pulse(p0, "tab_pulse", ok);
            if (ok) begin
                check("tab_data", obs_data, tab[i].exp_data);
                check("tab_sat", {31'd0, obs_sat}, {31'd0, tab[i].exp_sat});
                check("tab_err", {31'd0, obs_err}, 32'h0);
                check("tab_latency", 32'(obs_cyc - se), 32'd32);
            end
        end

        // Two-product negative saturation.
        p0 = pulses;
        drive(1, 0, 32'h8000_0000, 32'h7FFF_FFFF);
        drive(1, 1, 32'h8000_0000, 32'h7FFF_FFFF);
        drive(0, 0, 0, 0);
        wait_pulse(p0, "negsat_pulse", ok);
        if (ok) begin
            check("negsat_data", obs_data, 32'h8000_0000);
            check("negsat_sat", {31'd0, obs_sat}, 32'h1);
        end

        // Bubbles inside frame A, frame B immediately after A's last.
        p0 = pulses;
        drive(1, 0, 32'h4000_0000, 32'h4000_0000);
        repeat (3) drive(0, 1, 32'h1234_5678, 32'h7FFF_FFFF);
        drive(1, 1, 32'hE000_0000, 32'h4000_0000);
        drive(1, 1, 32'h2000_0000, 32'h2000_0000);
        drive(0, 0, 0, 0);
        wait_pulse(p0, "frameA_pulse", ok);
        cyc_a = obs_cyc;
        if (ok) check("frameA_data", obs_data, 32'h1000_0000);
        wait_pulse(p0 + 1, "frameB_pulse", ok);
        if (ok) begin
            check("frameB_data", obs_data, 32'h0800_0000);
            check("frameB_gap", 32'(obs_cyc - cyc_a), 32'd1);
        end

        // Reset while two products are in flight.
        repeat (4) drive(0, 0, 0, 0);
        p0 = pulses;
        drive(1, 0, 32'h4000_0000, 32'h4000_0000);
        drive(1, 1, 32'h4000_0000, 32'h4000_0000);
        repeat (7) drive(0, 0, 0, 0);
        do_reset();
        repeat (50) drive(0, 0, 0, 0);
        check("reset_no_pulse", 32'(pulses - p0), 32'd0);
        p0 = pulses;
        drive(1, 1, 32'hC000_0000, 32'h2000_0000);
        drive(0, 0, 0, 0);
        wait_pulse(p0, "post_reset_pulse", ok);
        if (ok) begin
            check("post_reset_data", obs_data, 32'hF000_0000);
            check("post_reset_sat", {31'd0, obs_sat}, 32'h0);
        end

        // Exactly MAX_LEN products: no error flag.
        p0 = pulses;
        for (int i = 0; i < 256; i++) drive(1, i == 255, 32'h0001_0000, 32'h0001_0000);
        drive(0, 0, 0, 0);
        wait_pulse(p0, "len256_pulse", ok);
        if (ok) begin
            check("len256_data", obs_data, 32'h0000_0200);
            check("len256_err", {31'd0, obs_err}, 32'h0);
        end

        // MAX_LEN+1 products: error flagged, result still produced.
        p0 = pulses;
        for (int i = 0; i < 257; i++) drive(1, i == 256, 32'h0001_0000, 32'h0001_0000);
        drive(0, 0, 0, 0);
        wait_pulse(p0, "len257_pulse", ok);
        if (ok) begin
            check("len257_data", obs_data, 32'h0000_0202);
            check("len257_sat", {31'd0, obs_sat}, 32'h0);
            check("len257_err", {31'd0, obs_err}, 32'h1);
        end

        // Random frames with bubbles, checked by the scoreboard.
        for (int f = 0; f < 60; f++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                while ($urandom_range(0, 3) == 0) drive(0, 1'($urandom_range(0, 1)), $urandom, $urandom);
                drive(1, k == len - 1, rnd_op(), rnd_op());
            end
        end
        repeat (LAT + 8) drive(0, 0, 0, 0);
        check("drain_empty", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
